// File: rtl/snitch_icache_pkg.sv
// rtl/snitch_icache_pkg.sv - shared types for the icache flush controller
package snitch_icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WALK  = 2'd2,
    L0    = 2'd3
  } flush_state_e;

endpackage

// File: rtl/cluster_icache_flush_ctrl.sv
// rtl/cluster_icache_flush_ctrl.sv - merges per-port flush requests, drains refills, walks the L1 tag RAM
module cluster_icache_flush_ctrl
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 4,
  parameter int unsigned SET_COUNT      = 128,
  parameter int unsigned WAY_COUNT      = 4,
  localparam int unsigned SET_W         = $clog2(SET_COUNT)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NR_FETCH_PORTS-1:0] flush_valid_i,
  output logic [NR_FETCH_PORTS-1:0] flush_ready_o,
  input  logic                      refill_busy_i,
  output logic                      lookup_block_o,
  output logic                      tag_write_valid_o,
  input  logic                      tag_write_ready_i,
  output logic [SET_W-1:0]          tag_write_addr_o,
  output logic [WAY_COUNT-1:0]      tag_write_way_o,
  output logic [NR_FETCH_PORTS-1:0] l0_flush_o
);

  flush_state_e              state_q, state_d;
  logic [SET_W-1:0]          set_q;
  logic [NR_FETCH_PORTS-1:0] pending_q, active_q;
  logic                      init_q;
  logic                      req_any;
  logic                      last_set;

  assign req_any  = |(pending_q | flush_valid_i);
  assign last_set = (set_q == SET_W'(SET_COUNT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DRAIN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = DRAIN;
      DRAIN:   if (!refill_busy_i) state_d = WALK;
      WALK:    if (tag_write_ready_i && last_set) state_d = L0;
      L0:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Requests seen outside IDLE are parked in pending_q and served by a later full pass.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      set_q     <= '0;
      pending_q <= '0;
      active_q  <= '0;
      init_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            active_q  <= pending_q | flush_valid_i;
            pending_q <= '0;
          end
        end
        DRAIN: begin
          pending_q <= pending_q | flush_valid_i;
          if (!refill_busy_i) set_q <= '0;
        end
        WALK: begin
          pending_q <= pending_q | flush_valid_i;
          if (tag_write_ready_i) set_q <= set_q + SET_W'(1);
        end
        L0: begin
          pending_q <= pending_q | flush_valid_i;
          active_q  <= '0;
          init_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    flush_ready_o     = init_q ? '0 : ~(pending_q | active_q);
    lookup_block_o    = (state_q != IDLE);
    tag_write_valid_o = (state_q == WALK);
    tag_write_addr_o  = set_q;
    tag_write_way_o   = (state_q == WALK) ? {WAY_COUNT{1'b1}} : '0;
    l0_flush_o        = (state_q == L0) ? active_q : '0;
  end

endmodule

// File: tb/tb_cluster_icache_flush_ctrl.sv
// tb/tb_cluster_icache_flush_ctrl.sv - directed self-checking bench for cluster_icache_flush_ctrl
module tb_cluster_icache_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flush_valid;
  logic [3:0] flush_ready;
  logic       refill_busy;
  logic       lookup_block;
  logic       tag_valid;
  logic       tag_ready;
  logic [2:0] tag_addr;
  logic [3:0] tag_way;
  logic [3:0] l0_flush;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cluster_icache_flush_ctrl #(
    .NR_FETCH_PORTS(4),
    .SET_COUNT(8),
    .WAY_COUNT(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_valid_i(flush_valid),
    .flush_ready_o(flush_ready),
    .refill_busy_i(refill_busy),
    .lookup_block_o(lookup_block),
    .tag_write_valid_o(tag_valid),
    .tag_write_ready_i(tag_ready),
    .tag_write_addr_o(tag_addr),
    .tag_write_way_o(tag_way),
    .l0_flush_o(l0_flush)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observes 8 consecutive accepted writes (tag ready held high), then the L0 cycle.
  task automatic walk_pass(input string tag, input logic [3:0] rdy, input logic [3:0] strobe);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_wvalid"}, 32'(tag_valid), 32'd1);
      check({tag, "_waddr"}, 32'(tag_addr), 32'(i));
      check({tag, "_wway"}, 32'(tag_way), 32'hf);
      check({tag, "_wready"}, 32'(flush_ready), 32'(rdy));
      check({tag, "_wl0"}, 32'(l0_flush), 32'd0);
      step();
    end
    check({tag, "_l0"}, 32'(l0_flush), 32'(strobe));
    check({tag, "_l0_wvalid"}, 32'(tag_valid), 32'd0);
    step();
    check({tag, "_idle_l0"}, 32'(l0_flush), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    flush_valid = 4'b0000;
    refill_busy = 1'b0;
    tag_ready   = 1'b1;
    step();
    step();
    check("rst_ready", 32'(flush_ready), 32'h0);
    check("rst_block", 32'(lookup_block), 32'd1);
    check("rst_wvalid", 32'(tag_valid), 32'd0);
    check("rst_way", 32'(tag_way), 32'h0);
    check("rst_l0", 32'(l0_flush), 32'h0);

    // 1: init pass after reset
    rst = 1'b0;
    step();
    walk_pass("init", 4'b0000, 4'b0000);
    check("init_done_ready", 32'(flush_ready), 32'hf);
    check("init_done_block", 32'(lookup_block), 32'd0);

    // 2: single port latency
    flush_valid = 4'b0010;
    step();
    flush_valid = 4'b0000;
    check("p1_drain_ready", 32'(flush_ready), 32'hd);
    check("p1_drain_block", 32'(lookup_block), 32'd1);
    check("p1_drain_wvalid", 32'(tag_valid), 32'd0);
    step();
    walk_pass("p1", 4'b1101, 4'b0010);
    check("p1_done_ready", 32'(flush_ready), 32'hf);

    // 3: simultaneous requests share one pass
    flush_valid = 4'b0101;
    step();
    flush_valid = 4'b0000;
    check("p02_drain_ready", 32'(flush_ready), 32'ha);
    step();
    walk_pass("p02", 4'b1010, 4'b0101);
    check("p02_done_ready", 32'(flush_ready), 32'hf);

    // 4: port 3 requests mid-walk and gets its own second pass
    flush_valid = 4'b0001;
    step();
    flush_valid = 4'b0000;
    step();
    for (int i = 0; i < 8; i++) begin
      check("mid_waddr", 32'(tag_addr), 32'(i));
      check("mid_ready", 32'(flush_ready), (i > 4) ? 32'h6 : 32'he);
      flush_valid = (i == 4) ? 4'b1000 : 4'b0000;
      step();
    end
    flush_valid = 4'b0000;
    check("mid_l0_first", 32'(l0_flush), 32'h1);
    check("mid_l0_ready", 32'(flush_ready), 32'h6);
    step();
    check("mid_idle_ready", 32'(flush_ready), 32'h7);
    check("mid_idle_block", 32'(lookup_block), 32'd0);
    step();
    check("mid_drain2_ready", 32'(flush_ready), 32'h7);
    check("mid_drain2_wvalid", 32'(tag_valid), 32'd0);
    step();
    walk_pass("mid2", 4'b0111, 4'b1000);
    check("mid_done_ready", 32'(flush_ready), 32'hf);

    // 5: refill drain then a stalling tag port
    flush_valid = 4'b0100;
    refill_busy = 1'b1;
    step();
    flush_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      check("drain_hold_wvalid", 32'(tag_valid), 32'd0);
      check("drain_hold_block", 32'(lookup_block), 32'd1);
      step();
    end
    refill_busy = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      tag_ready = 1'b0;
      step();
      check("stall_wvalid", 32'(tag_valid), 32'd1);
      check("stall_addr", 32'(tag_addr), 32'(i));
      tag_ready = 1'b1;
      step();
    end
    check("stall_l0", 32'(l0_flush), 32'h4);
    step();
    check("stall_done_ready", 32'(flush_ready), 32'hf);

    // 6: reset in the middle of a walk restarts the init pass
    flush_valid = 4'b0010;
    step();
    flush_valid = 4'b0000;
    step();
    for (int i = 0; i < 5; i++) step();
    check("abort_addr", 32'(tag_addr), 32'd5);
    rst = 1'b1;
    step();
    check("abort_rst_ready", 32'(flush_ready), 32'h0);
    check("abort_rst_wvalid", 32'(tag_valid), 32'd0);
    check("abort_rst_block", 32'(lookup_block), 32'd1);
    rst = 1'b0;
    step();
    walk_pass("reinit", 4'b0000, 4'b0000);
    check("reinit_done_ready", 32'(flush_ready), 32'hf);
    step();
    check("reinit_stay_idle", 32'(lookup_block), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
